// File: rtl/mac_pe.sv
// mac_pe: systolic multiply-accumulate processing element.
//
// Multiplies paired A/B operands and accumulates them into a running
// dot-product. A is forwarded right and B forwarded down through one register
// stage, so instances tile into an R x C array. A completed dot-product moves
// into a result register drained by a valid/ready handshake. This lets the
// next dot-product accumulate while the previous result waits.
//
// Parameters:
//   DATA_W   operand width
//   ACC_W    accumulator/result width (must be >= 2*DATA_W)
//   SIGNED   1 = two's-complement operands, 0 = unsigned
//   SATURATE 1 = clamp on overflow, 0 = wrap modulo 2^ACC_W
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   a_in/a_valid_in/a_last_in         A operand from the left neighbour
//   b_in/b_valid_in/b_last_in         B operand from the upper neighbour
//   a_out/a_valid_out/a_last_out      registered A forward to the right
//   b_out/b_valid_out/b_last_out      registered B forward downwards
//   c_out/c_valid/c_ready             completed result handshake
//   c_sat                             result overflowed (clamped or wrapped)
//   busy                              partial sum in progress
//   err                               sticky protocol/overrun error
module mac_pe #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_valid_in,
  input  logic              a_last_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_valid_in,
  input  logic              b_last_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_valid_out,
  output logic              a_last_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_valid_out,
  output logic              b_last_out,
  output logic [ACC_W-1:0]  c_out,
  output logic              c_valid,
  input  logic              c_ready,
  output logic              c_sat,
  output logic              busy,
  output logic              err
);

  if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
    $error("mac_pe: ACC_W must be at least 2*DATA_W");
  end

  localparam int PW = 2 * DATA_W;

  localparam logic [ACC_W-1:0] ACC_MAX =
    SIGNED ? {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] ACC_MIN =
    SIGNED ? {1'b1, {(ACC_W-1){1'b0}}} : {ACC_W{1'b0}};
  // Ones above the product width. These bits are filled to sign-extend a negative product.
  localparam logic [ACC_W-1:0] HIGH_MASK = ~ACC_W'({PW{1'b1}});

  typedef enum logic {ACC_IDLE, ACC_ACCUM} acc_state_t;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  acc_state_t acc_state, acc_next;
  out_state_t out_state, out_next;

  logic [ACC_W-1:0] acc;
  logic             acc_sat;

  logic [PW-1:0]    a_ext, b_ext, prod;
  logic [ACC_W-1:0] prod_ext, sum_raw, sum_final;
  logic             carry, pos_ovf, neg_ovf, sum_sat;

  logic pair, proto_err, accept, last_pair, overrun, load_result;

  // Handshake qualification. A pair counts only when both sides are valid
  // and agree on "last". A one-sided valid, or a disagreement on "last", is
  // a protocol error. The pair is then dropped without being accumulated.
  always_comb begin
    pair        = a_valid_in & b_valid_in;
    proto_err   = (a_valid_in ^ b_valid_in) | (pair & (a_last_in ^ b_last_in));
    accept      = pair & ~(a_last_in ^ b_last_in);
    last_pair   = accept & a_last_in;
    overrun     = last_pair & (out_state == OUT_FULL) & ~c_ready;
    load_result = last_pair & ~overrun;
  end

  // Multiply at full 2*DATA_W precision. Both operands are pre-extended to
  // 2*DATA_W, so the low half of the product is exact for either signedness.
  // The product is then extended to the accumulator width, and the
  // accumulator update is computed with overflow detection.
  always_comb begin
    a_ext = SIGNED ? {{DATA_W{a_in[DATA_W-1]}}, a_in} : {{DATA_W{1'b0}}, a_in};
    b_ext = SIGNED ? {{DATA_W{b_in[DATA_W-1]}}, b_in} : {{DATA_W{1'b0}}, b_in};
    prod  = a_ext * b_ext;

    prod_ext = ACC_W'(prod);
    if (SIGNED && prod[PW-1]) begin
      prod_ext = prod_ext | HIGH_MASK;
    end

    {carry, sum_raw} = {1'b0, acc} + {1'b0, prod_ext};

    if (SIGNED) begin
      pos_ovf = ~acc[ACC_W-1] & ~prod_ext[ACC_W-1] &  sum_raw[ACC_W-1];
      neg_ovf =  acc[ACC_W-1] &  prod_ext[ACC_W-1] & ~sum_raw[ACC_W-1];
    end else begin
      pos_ovf = carry;
      neg_ovf = 1'b0;
    end

    sum_final = sum_raw;
    if (SATURATE) begin
      if (pos_ovf) begin
        sum_final = ACC_MAX;
      end else if (neg_ovf) begin
        sum_final = ACC_MIN;
      end
    end
    sum_sat = acc_sat | pos_ovf | neg_ovf;
  end

  // Accumulator FSM. A last pair always returns to IDLE, including a
  // single-element dot-product that starts from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_state <= ACC_IDLE;
    end else begin
      acc_state <= acc_next;
    end
  end

  always_comb begin
    acc_next = acc_state;
    if (accept) begin
      acc_next = last_pair ? ACC_IDLE : ACC_ACCUM;
    end
  end

  // The accumulator clears whenever a final sum leaves it. This includes an
  // overrun, where the final sum itself is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      acc_sat <= 1'b0;
    end else if (accept) begin
      if (last_pair) begin
        acc     <= '0;
        acc_sat <= 1'b0;
      end else begin
        acc     <= sum_final;
        acc_sat <= sum_sat;
      end
    end
  end

  // Output FSM. A new result may load in the same cycle the old one drains.
  // The register then stays FULL with the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_state <= OUT_EMPTY;
    end else begin
      out_state <= out_next;
    end
  end

  always_comb begin
    out_next = out_state;
    if (load_result) begin
      out_next = OUT_FULL;
    end else if (out_state == OUT_FULL && c_ready) begin
      out_next = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_out <= '0;
      c_sat <= 1'b0;
    end else if (load_result) begin
      c_out <= sum_final;
      c_sat <= sum_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (proto_err || overrun) begin
      err <= 1'b1;
    end
  end

  // Systolic forwarding is unconditional. Neighbours see every input one
  // cycle later, whatever this element's state.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out       <= '0;
      a_valid_out <= 1'b0;
      a_last_out  <= 1'b0;
      b_out       <= '0;
      b_valid_out <= 1'b0;
      b_last_out  <= 1'b0;
    end else begin
      a_out       <= a_in;
      a_valid_out <= a_valid_in;
      a_last_out  <= a_last_in;
      b_out       <= b_in;
      b_valid_out <= b_valid_in;
      b_last_out  <= b_last_in;
    end
  end

  assign busy    = (acc_state == ACC_ACCUM);
  assign c_valid = (out_state == OUT_FULL);

endmodule

// File: tb/tb_mac_pe.sv
// tb_mac_pe: directed testbench for mac_pe.
//
// The main instance uses the default parameters (16-bit signed, 40-bit
// saturating accumulator). Two extra instances use a 32-bit accumulator, one
// saturating and one wrapping, to exercise overflow. All three share the same
// input stimulus.
module tb_mac_pe;

  logic        clk;
  logic        rst;
  logic [15:0] a_in, b_in;
  logic        a_valid_in, a_last_in, b_valid_in, b_last_in;
  logic        c_ready;

  logic [15:0] a_out, b_out;
  logic        a_valid_out, a_last_out, b_valid_out, b_last_out;
  logic [39:0] c_out;
  logic        c_valid, c_sat, busy, err;

  logic [15:0] s_a_out, s_b_out;
  logic        s_a_valid_out, s_a_last_out, s_b_valid_out, s_b_last_out;
  logic [31:0] s_c_out;
  logic        s_c_valid, s_c_sat, s_busy, s_err;

  logic [15:0] w_a_out, w_b_out;
  logic        w_a_valid_out, w_a_last_out, w_b_valid_out, w_b_last_out;
  logic [31:0] w_c_out;
  logic        w_c_valid, w_c_sat, w_busy, w_err;

  int tests_run;
  int tests_failed;

  mac_pe #(.DATA_W(16), .ACC_W(40), .SIGNED(1'b1), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_last_in(a_last_in),
    .b_in(b_in), .b_valid_in(b_valid_in), .b_last_in(b_last_in),
    .a_out(a_out), .a_valid_out(a_valid_out), .a_last_out(a_last_out),
    .b_out(b_out), .b_valid_out(b_valid_out), .b_last_out(b_last_out),
    .c_out(c_out), .c_valid(c_valid), .c_ready(c_ready),
    .c_sat(c_sat), .busy(busy), .err(err)
  );

  mac_pe #(.DATA_W(16), .ACC_W(32), .SIGNED(1'b1), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_last_in(a_last_in),
    .b_in(b_in), .b_valid_in(b_valid_in), .b_last_in(b_last_in),
    .a_out(s_a_out), .a_valid_out(s_a_valid_out), .a_last_out(s_a_last_out),
    .b_out(s_b_out), .b_valid_out(s_b_valid_out), .b_last_out(s_b_last_out),
    .c_out(s_c_out), .c_valid(s_c_valid), .c_ready(c_ready),
    .c_sat(s_c_sat), .busy(s_busy), .err(s_err)
  );

  mac_pe #(.DATA_W(16), .ACC_W(32), .SIGNED(1'b1), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_last_in(a_last_in),
    .b_in(b_in), .b_valid_in(b_valid_in), .b_last_in(b_last_in),
    .a_out(w_a_out), .a_valid_out(w_a_valid_out), .a_last_out(w_a_last_out),
    .b_out(w_b_out), .b_valid_out(w_b_valid_out), .b_last_out(w_b_last_out),
    .c_out(w_c_out), .c_valid(w_c_valid), .c_ready(c_ready),
    .c_sat(w_c_sat), .busy(w_busy), .err(w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge. Outputs are sampled 1 time unit after
  // the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic av, input logic al,
                       input logic [15:0] b, input logic bv, input logic bl);
    a_in = a; a_valid_in = av; a_last_in = al;
    b_in = b; b_valid_in = bv; b_last_in = bl;
  endtask

  task automatic idle();
    drive(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    c_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests_run++; if (c_out !== 40'h0) begin tests_failed++; $display("[TB] FAIL reset_c_out: got %h expected 0", c_out); end
    tests_run++; if (c_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_c_valid: got %b expected 0", c_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    tests_run++; if (c_sat !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_c_sat: got %b expected 0", c_sat); end
    tests_run++; if ({a_out, a_valid_out, a_last_out, b_out, b_valid_out, b_last_out} !== 34'h0) begin
      tests_failed++; $display("[TB] FAIL reset_forward: got a=%h b=%h expected all 0", a_out, b_out); end
  endtask

  // (3,4) + (-2,5) + (7,-1) = 12 - 10 - 7 = -5
  task automatic test_dot_product();
    do_reset();
    c_ready = 1'b0;
    drive(16'd3, 1'b1, 1'b0, 16'd4, 1'b1, 1'b0);
    tick();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL dot_busy_mid: got %b expected 1", busy); end
    drive(16'hFFFE, 1'b1, 1'b0, 16'd5, 1'b1, 1'b0);
    tick();
    drive(16'd7, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    tick();
    idle();
    tests_run++; if (c_out !== 40'hFFFFFFFFFB) begin tests_failed++; $display("[TB] FAIL dot_c_out: got %h expected fffffffffb", c_out); end
    tests_run++; if (c_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL dot_c_valid: got %b expected 1", c_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL dot_busy_end: got %b expected 0", busy); end
    tests_run++; if (c_sat !== 1'b0) begin tests_failed++; $display("[TB] FAIL dot_c_sat: got %b expected 0", c_sat); end
    tick();
    tests_run++; if (c_out !== 40'hFFFFFFFFFB || c_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL dot_hold: got %h/%b expected fffffffffb/1", c_out, c_valid); end
    c_ready = 1'b1;
    tick();
    tests_run++; if (c_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL dot_drain: got %b expected 0", c_valid); end
  endtask

  task automatic test_forwarding();
    do_reset();
    c_ready = 1'b1;
    // A valid alone: forwarded, flagged as an error, not accumulated.
    drive(16'h1234, 1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0);
    tick();
    tests_run++; if (a_out !== 16'h1234 || a_valid_out !== 1'b1 || a_last_out !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL fwd_a: got %h/%b/%b expected 1234/1/1", a_out, a_valid_out, a_last_out); end
    tests_run++; if (b_out !== 16'hABCD || b_valid_out !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL fwd_b_data: got %h/%b expected abcd/0", b_out, b_valid_out); end
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("[TB] FAIL fwd_err: got %b expected 1", err); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL fwd_busy: got %b expected 0", busy); end
    drive(16'h0000, 1'b0, 1'b0, 16'h5678, 1'b1, 1'b1);
    tick();
    tests_run++; if (b_out !== 16'h5678 || b_valid_out !== 1'b1 || b_last_out !== 1'b1 || a_valid_out !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL fwd_b: got %h/%b/%b av=%b expected 5678/1/1 av=0", b_out, b_valid_out, b_last_out, a_valid_out); end
    // The accumulator was untouched, so a single last pair gives just its product.
    drive(16'd2, 1'b1, 1'b1, 16'd3, 1'b1, 1'b1);
    tick();
    idle();
    tests_run++; if (c_out !== 40'd6 || c_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL fwd_acc_clean: got %h/%b expected 6/1", c_out, c_valid); end
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("[TB] FAIL fwd_err_sticky: got %b expected 1", err); end
    // Mismatched last flags are an error and are not accumulated.
    do_reset();
    drive(16'd4, 1'b1, 1'b1, 16'd4, 1'b1, 1'b0);
    tick();
    idle();
    tests_run++; if (err !== 1'b1 || busy !== 1'b0 || c_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL last_mismatch: got err=%b busy=%b cv=%b expected 1/0/0", err, busy, c_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    c_ready = 1'b1;
    drive(16'd1, 1'b1, 1'b0, 16'd1, 1'b1, 1'b0);
    tick();
    drive(16'd1, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1);
    tick();
    tests_run++; if (c_out !== 40'd2 || c_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_first: got %h/%b expected 2/1", c_out, c_valid); end
    drive(16'd2, 1'b1, 1'b1, 16'd2, 1'b1, 1'b1);
    tick();
    idle();
    tests_run++; if (c_out !== 40'd4 || c_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_second: got %h/%b expected 4/1", c_out, c_valid); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_err: got %b expected 0", err); end
    tick();
    tests_run++; if (c_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_drain: got %b expected 0", c_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    c_ready = 1'b0;
    drive(16'd2, 1'b1, 1'b1, 16'd5, 1'b1, 1'b1);
    tick();
    tests_run++; if (c_out !== 40'd10 || c_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_first: got %h/%b expected 10/1", c_out, c_valid); end
    drive(16'd3, 1'b1, 1'b1, 16'd3, 1'b1, 1'b1);
    tick();
    idle();
    tests_run++; if (c_out !== 40'd10 || c_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_kept: got %h/%b expected 10/1", c_out, c_valid); end
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_err: got %b expected 1", err); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_busy: got %b expected 0", busy); end
    c_ready = 1'b1;
    tick();
    tests_run++; if (c_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_drain: got %b expected 0", c_valid); end
    // The overrun cleared the accumulator, so the next result starts from zero.
    drive(16'd1, 1'b1, 1'b1, 16'd7, 1'b1, 1'b1);
    tick();
    idle();
    tests_run++; if (c_out !== 40'd7) begin tests_failed++; $display("[TB] FAIL bp_acc_cleared: got %h expected 7", c_out); end
  endtask

  // 32767^2 = 0x3FFF0001. Three of them = 0xBFFD0003 overflows a signed 32-bit accumulator.
  // -32768*32767 = -0x3FFF8000. Three of them = -0xBFFE8000 underflows.
  task automatic test_saturation();
    do_reset();
    c_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(16'h7FFF, 1'b1, (i == 2), 16'h7FFF, 1'b1, (i == 2));
      tick();
    end
    idle();
    tests_run++; if (s_c_out !== 32'h7FFFFFFF || s_c_sat !== 1'b1) begin tests_failed++; $display("[TB] FAIL sat_pos: got %h/%b expected 7fffffff/1", s_c_out, s_c_sat); end
    tests_run++; if (w_c_out !== 32'hBFFD0003 || w_c_sat !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_pos: got %h/%b expected bffd0003/1", w_c_out, w_c_sat); end
    tests_run++; if (c_out !== 40'h00BFFD0003 || c_sat !== 1'b0) begin tests_failed++; $display("[TB] FAIL wide_pos: got %h/%b expected 00bffd0003/0", c_out, c_sat); end
    for (int i = 0; i < 3; i++) begin
      drive(16'h8000, 1'b1, (i == 2), 16'h7FFF, 1'b1, (i == 2));
      tick();
    end
    idle();
    tests_run++; if (s_c_out !== 32'h80000000 || s_c_sat !== 1'b1) begin tests_failed++; $display("[TB] FAIL sat_neg: got %h/%b expected 80000000/1", s_c_out, s_c_sat); end
    tests_run++; if (w_c_out !== 32'h40018000 || w_c_sat !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_neg: got %h/%b expected 40018000/1", w_c_out, w_c_sat); end
    tests_run++; if (c_out !== 40'hFF40018000 || c_sat !== 1'b0) begin tests_failed++; $display("[TB] FAIL wide_neg: got %h/%b expected ff40018000/0", c_out, c_sat); end
    // The saturation flag belongs to one dot-product and does not carry over.
    drive(16'd1, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1);
    tick();
    idle();
    tests_run++; if (s_c_out !== 32'd1 || s_c_sat !== 1'b0) begin tests_failed++; $display("[TB] FAIL sat_clear: got %h/%b expected 1/0", s_c_out, s_c_sat); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    c_ready = 1'b0;
    drive(16'd5, 1'b1, 1'b0, 16'd5, 1'b1, 1'b0);
    tick();
    drive(16'd9, 1'b1, 1'b1, 16'd9, 1'b1, 1'b1);
    tick();
    drive(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    tests_run++; if (err !== 1'b1 || c_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_setup: got err=%b cv=%b expected 1/1", err, c_valid); end
    // Reset has priority even while a valid pair is presented.
    drive(16'h1111, 1'b1, 1'b0, 16'h2222, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++; if (err !== 1'b0 || busy !== 1'b0 || c_valid !== 1'b0 || c_out !== 40'h0) begin
      tests_failed++; $display("[TB] FAIL rstmid_clear: got err=%b busy=%b cv=%b c=%h expected 0/0/0/0", err, busy, c_valid, c_out); end
    tests_run++; if (a_out !== 16'h0 || a_valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_fwd: got %h/%b expected 0/0", a_out, a_valid_out); end
    drive(16'd1, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1);
    tick();
    idle();
    tests_run++; if (c_out !== 40'd1 || c_valid !== 1'b1 || err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL rstmid_result: got %h/%b err=%b expected 1/1 err=0", c_out, c_valid, err); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    c_ready      = 1'b0;
    idle();
    test_reset();
    test_dot_product();
    test_forwarding();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mac_pe.md
# mac_pe

Parametrised systolic multiply-accumulate processing element; successor to the fixed 32-bit MAC. Each instance multiplies paired A/B operands, accumulates them per dot-product, and forwards operands right (A) and down (B) with one register stage so instances tile into an R×C array. Completed results go to a double-buffered output register with a valid/ready handshake, so the next dot-product can accumulate while the previous result drains.

## Interface
- DATA_W, 16, operand width.
- ACC_W, 40, accumulator/result width; must be ≥ 2*DATA_W (elaboration error otherwise).
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.
- SATURATE, 1, 1 = clamp accumulator at ACC_W limits, 0 = wrap modulo 2^ACC_W.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- a_in  in  DATA_W  A operand from left neighbour.
- a_valid_in  in  1  a_in valid.
- a_last_in  in  1  final A element of current dot-product.
- b_in  in  DATA_W  B operand from upper neighbour.
- b_valid_in  in  1  b_in valid.
- b_last_in  in  1  final B element of current dot-product.
- a_out / a_valid_out / a_last_out  out  DATA_W/1/1  registered A forward to right neighbour.
- b_out / b_valid_out / b_last_out  out  DATA_W/1/1  registered B forward to lower neighbour.
- c_out  out  ACC_W  completed dot-product.
- c_valid  out  1  c_out holds an unconsumed result.
- c_ready  in  1  consumer accepts c_out.
- c_sat  out  1  result in c_out saturated (SATURATE=1) or wrapped (SATURATE=0) at least once.
- busy  out  1  accumulator holds a partial sum (≥1 pair accepted since last clear).
- err  out  1  sticky protocol error; cleared only by rst.

## Operation
- Forwarding: every cycle a_out/a_valid_out/a_last_out ← inputs, same for B; unconditional (independent of err, c_ready, state).
- Pair accepted when a_valid_in & b_valid_in. Product = a_in*b_in at 2*DATA_W, sign- (SIGNED=1) or zero-extended to ACC_W, added to acc.
- SATURATE=1: on positive overflow acc ← max (signed 2^(ACC_W-1)-1 / unsigned all-ones), on negative ← min; set acc_sat. SATURATE=0: wrap, set acc_sat on overflow.
- Last pair: accepted pair with a_last_in & b_last_in. Final sum (acc + product, same overflow rule) moves to result register with acc_sat; acc ← 0, acc_sat ← 0, busy ← 0 same edge.
- Accumulator FSM: IDLE (acc=0) → ACCUM on a non-last pair; ACCUM stays on non-last pairs; IDLE/ACCUM → IDLE on last pair (single-element dot-product legal from IDLE).
- Output FSM: EMPTY → FULL when a final sum loads; FULL → EMPTY on c_valid & c_ready with no new final sum that cycle; FULL stays FULL if accepted and new final sum loads same cycle (new value replaces).
- Overrun: final sum arrives while FULL and c_ready=0 → new result dropped, old c_out kept, err ← 1; acc still clears.
- Protocol errors (err ← 1, pair not accumulated): exactly one of a_valid_in/b_valid_in high; both valid with a_last_in ≠ b_last_in. Forwarding unaffected.
- Inputs with valid low are ignored (last flags qualified by valid).

## Timing
- Reset values: a_out, b_out, c_out = 0; all valid/last outputs 0; c_valid, c_sat, busy, err = 0; acc = 0; both FSMs in IDLE/EMPTY.
- Forward latency: 1 cycle.
- Result latency: c_valid high the cycle after the edge sampling the last pair; c_out stable while c_valid & !c_ready.
- Throughput: one pair per cycle; back-to-back dot-products with no bubble when consumer keeps c_ready high.
- rst mid-operation: partial sum, pending result and err discarded on that edge; rst has priority over all inputs.

## Test plan
- SIGNED=1, DATA_W=16: pairs (3,4),(−2,5),(7,−1 last) → c_out=−5 one cycle after last, c_valid=1, busy=0, c_sat=0.
- Forwarding: a_in=0x1234 valid cycle 0 → a_out=0x1234, a_valid_out=1 at cycle 1; same for B; holds with a_valid_in only (err=1, acc unchanged).
- Back-to-back: dot-products {(1,1),(1,1 last)} then {(2,2 last)}, c_ready=1 → c_out=2 then 4 on consecutive valid cycles, no drop.
- Backpressure: c_ready=0, result 10 pending, second last pair arrives → c_out stays 10, err=1; raising c_ready clears c_valid next cycle.
- Saturation: ACC_W=32, DATA_W=16, SIGNED=1, repeated (32767,32767) ×3 last → c_out=0x7FFFFFFF, c_sat=1; SATURATE=0 gives wrapped sum, c_sat=1.
- Reset mid-accumulation after (5,5): rst one cycle, then (1,1 last) → c_out=1, err=0.
